// File: rtl/edge_recorder.sv
// Edge timestamp recorder: timestamps edges of the selected channel inside its sync
// window and writes 4-byte records into external SRAM, one byte per 3-clk write cycle.
module edge_recorder #(
  parameter int TS_W      = 31,
  parameter int BIG_CH_LO = 10,
  parameter int BIG_CH_HI = 13,
  parameter int MAX_CH    = 25
) (
  input  logic        clk,
  input  logic        mcu_n_rst,
  input  logic        sample_en,
  input  logic        ch_sgn,
  input  logic        ch_sync,
  input  logic [7:0]  sync_cnt,
  input  logic [19:0] addr_base,
  output logic [19:0] sram_addr,
  output logic [7:0]  sram_data,
  output logic        sram_we_n,
  output logic        sram_bus_en,
  output logic [15:0] pulse_cnt,
  output logic [31:0] clk_cnt,
  output logic [15:0] rec_cnt,
  output logic        ovf
);

  // state  | meaning
  // IDLE   | bus released, waiting for a pending edge
  // SETUP  | address and data driven onto the bus
  // STROBE | write strobe asserted
  // HOLD   | strobe released, address and data still stable
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [7:0] CH_LO  = 8'(BIG_CH_LO);
  localparam logic [7:0] CH_HI  = 8'(BIG_CH_HI);
  localparam logic [7:0] CH_MAX = 8'(MAX_CH);

  state_t state, state_nxt;

  logic sgn_m, sgn_s, sgn_d;
  logic syn_m, syn_s, syn_d;
  logic en_d;

  logic [TS_W-1:0] ts_live;
  logic [15:0]     pulse_live;
  logic [15:0]     rec_live;
  logic [16:0]     offset;
  logic [19:0]     win_base;
  logic [7:0]      win_ch;

  logic            pend_vld;
  logic [TS_W-1:0] pend_ts;
  logic            pend_lvl;

  logic [TS_W-1:0] rec_ts;
  logic            rec_lvl;
  logic [19:0]     rec_addr;
  logic [1:0]      byte_idx, byte_nxt;

  logic            ld, done;
  logic            edge_det, rise, win_start, win_valid, active, big;
  logic [16:0]     limit, need;
  logic            region_full, accept, lost;
  logic [19:0]     src_addr;
  logic [TS_W-1:0] src_ts;
  logic            src_lvl;
  logic [7:0]      wr_byte;

  always_ff @(posedge clk or negedge mcu_n_rst) begin
    if (!mcu_n_rst) begin
      sgn_m <= 1'b0;
      sgn_s <= 1'b0;
      sgn_d <= 1'b0;
      syn_m <= 1'b0;
      syn_s <= 1'b0;
      syn_d <= 1'b0;
      en_d  <= 1'b0;
    end else begin
      sgn_m <= ch_sgn;
      sgn_s <= sgn_m;
      sgn_d <= sgn_s;
      syn_m <= ch_sync;
      syn_s <= syn_m;
      syn_d <= syn_s;
      en_d  <= sample_en;
    end
  end

  assign edge_det  = sgn_s ^ sgn_d;
  assign rise      = sgn_s & ~sgn_d;
  assign win_start = syn_s & ~syn_d;
  assign win_valid = (win_ch != 8'd0) && (win_ch <= CH_MAX);
  assign active    = sample_en && syn_s && win_valid && !win_start;
  assign big       = (win_ch >= CH_LO) && (win_ch <= CH_HI);
  assign limit     = big ? 17'h10000 : 17'h01000;

  // Space for the record in flight (or about to be loaded) is reserved up front
  assign need        = offset + 17'd4 + (((state != IDLE) || pend_vld) ? 17'd4 : 17'd0);
  assign region_full = need > limit;
  assign accept      = active && edge_det && (!pend_vld || ld) && !region_full;
  assign lost        = active && edge_det && ((pend_vld && !ld) || region_full);

  always_comb begin
    state_nxt = state;
    byte_nxt  = byte_idx;
    ld        = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (pend_vld && sample_en && !win_start) begin
          ld        = 1'b1;
          byte_nxt  = 2'd0;
          state_nxt = SETUP;
        end
      end
      SETUP:  state_nxt = STROBE;
      STROBE: state_nxt = HOLD;
      HOLD: begin
        if (byte_idx == 2'd3) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (!sample_en) begin
          state_nxt = IDLE;
        end else begin
          byte_nxt  = byte_idx + 2'd1;
          state_nxt = SETUP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign src_addr = ld ? (win_base + {3'b000, offset}) : rec_addr;
  assign src_ts   = ld ? pend_ts : rec_ts;
  assign src_lvl  = ld ? pend_lvl : rec_lvl;

  always_comb begin
    wr_byte = 8'd0;
    case (byte_nxt)
      2'd0:    wr_byte = src_ts[7:0];
      2'd1:    wr_byte = src_ts[15:8];
      2'd2:    wr_byte = src_ts[23:16];
      default: wr_byte = {src_lvl, src_ts[30:24]};
    endcase
  end

  always_ff @(posedge clk or negedge mcu_n_rst) begin
    if (!mcu_n_rst) begin
      state       <= IDLE;
      byte_idx    <= 2'd0;
      rec_ts      <= '0;
      rec_lvl     <= 1'b0;
      rec_addr    <= 20'd0;
      sram_addr   <= 20'd0;
      sram_data   <= 8'd0;
      sram_we_n   <= 1'b1;
      sram_bus_en <= 1'b0;
    end else begin
      state       <= state_nxt;
      byte_idx    <= byte_nxt;
      sram_we_n   <= (state_nxt != STROBE);
      sram_bus_en <= (state_nxt != IDLE);
      if (ld) begin
        rec_ts   <= pend_ts;
        rec_lvl  <= pend_lvl;
        rec_addr <= src_addr;
      end
      if (state_nxt == SETUP) begin
        sram_addr <= src_addr + {18'd0, byte_nxt};
        sram_data <= wr_byte;
      end
    end
  end

  always_ff @(posedge clk or negedge mcu_n_rst) begin
    if (!mcu_n_rst) begin
      ts_live    <= '0;
      pulse_live <= 16'd0;
      rec_live   <= 16'd0;
      offset     <= 17'd0;
      win_base   <= 20'd0;
      win_ch     <= 8'd0;
      pulse_cnt  <= 16'd0;
      clk_cnt    <= 32'd0;
      rec_cnt    <= 16'd0;
      pend_vld   <= 1'b0;
      pend_ts    <= '0;
      pend_lvl   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (win_start) begin
        pulse_cnt  <= pulse_live;
        clk_cnt    <= 32'(ts_live);
        rec_cnt    <= rec_live;
        win_base   <= addr_base;
        win_ch     <= sync_cnt;
        ts_live    <= '0;
        pulse_live <= 16'd0;
        // a record finishing right now belongs to the new window
        rec_live   <= done ? 16'd1 : 16'd0;
        offset     <= done ? 17'd4 : 17'd0;
      end else begin
        if (active && (ts_live != '1))
          ts_live <= ts_live + 1'b1;
        if (active && rise && (pulse_live != 16'hFFFF))
          pulse_live <= pulse_live + 16'd1;
        if (done) begin
          offset <= offset + 17'd4;
          if (rec_live != 16'hFFFF)
            rec_live <= rec_live + 16'd1;
        end
      end

      if (win_start || !sample_en) begin
        pend_vld <= 1'b0;
      end else if (accept) begin
        pend_vld <= 1'b1;
        pend_ts  <= ts_live;
        pend_lvl <= sgn_s;
      end else if (ld) begin
        pend_vld <= 1'b0;
      end

      if (sample_en && !en_d)
        ovf <= 1'b0;
      else if (lost)
        ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_edge_recorder.sv
// Directed bench for edge_recorder: SRAM writes are logged at the strobe and compared
// against hand-computed records and window counters.
module tb_edge_recorder;

  logic        clk = 1'b0;
  logic        mcu_n_rst;
  logic        sample_en;
  logic        ch_sgn;
  logic        ch_sync;
  logic [7:0]  sync_cnt;
  logic [19:0] addr_base;
  logic [19:0] sram_addr;
  logic [7:0]  sram_data;
  logic        sram_we_n;
  logic        sram_bus_en;
  logic [15:0] pulse_cnt;
  logic [31:0] clk_cnt;
  logic [15:0] rec_cnt;
  logic        ovf;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [19:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  int          wr_cyc[$];

  edge_recorder dut (
    .clk         (clk),
    .mcu_n_rst   (mcu_n_rst),
    .sample_en   (sample_en),
    .ch_sgn      (ch_sgn),
    .ch_sync     (ch_sync),
    .sync_cnt    (sync_cnt),
    .addr_base   (addr_base),
    .sram_addr   (sram_addr),
    .sram_data   (sram_data),
    .sram_we_n   (sram_we_n),
    .sram_bus_en (sram_bus_en),
    .pulse_cnt   (pulse_cnt),
    .clk_cnt     (clk_cnt),
    .rec_cnt     (rec_cnt),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mcu_n_rst && !sram_we_n) begin
      wr_addr.push_back(sram_addr);
      wr_data.push_back(sram_data);
      wr_cyc.push_back(cyc);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // drop sync, set the channel level while outside the window, then open a new window
  task automatic win_next(input logic [7:0] ch, input logic [19:0] base, input logic lvl);
    ch_sync = 1'b0;
    ch_sgn  = lvl;
    tick(4);
    sync_cnt  = ch;
    addr_base = base;
    ch_sync   = 1'b1;
  endtask

  task automatic chk_rec(input int idx, input logic [19:0] addr, input logic [30:0] ts,
                         input logic lvl);
    logic [7:0] exp_b[4];
    exp_b[0] = ts[7:0];
    exp_b[1] = ts[15:8];
    exp_b[2] = ts[23:16];
    exp_b[3] = {lvl, ts[30:24]};
    if (wr_addr.size() < idx + 4) begin
      check("rec_present", wr_addr.size(), idx + 4);
      return;
    end
    for (int b = 0; b < 4; b++) begin
      check($sformatf("rec%0d_addr%0d", idx, b), {12'd0, wr_addr[idx+b]}, {12'd0, addr + 20'(b)});
      check($sformatf("rec%0d_data%0d", idx, b), {24'd0, wr_data[idx+b]}, {24'd0, exp_b[b]});
    end
  endtask

  initial begin
    mcu_n_rst = 1'b0;
    sample_en = 1'b0;
    ch_sgn    = 1'b0;
    ch_sync   = 1'b0;
    sync_cnt  = 8'd0;
    addr_base = 20'd0;
    tick(2);
    check("rst_addr",   {12'd0, sram_addr}, 32'd0);
    check("rst_data",   {24'd0, sram_data}, 32'd0);
    check("rst_we_n",   {31'd0, sram_we_n}, 32'd1);
    check("rst_bus_en", {31'd0, sram_bus_en}, 32'd0);
    check("rst_pulse",  {16'd0, pulse_cnt}, 32'd0);
    check("rst_clk",    clk_cnt, 32'd0);
    check("rst_rec",    {16'd0, rec_cnt}, 32'd0);
    check("rst_ovf",    {31'd0, ovf}, 32'd0);
    mcu_n_rst = 1'b1;
    tick(2);
    sample_en = 1'b1;
    tick(2);

    // single rising edge 100 clk after sync rise: ts = 99
    clear_log();
    win_next(8'd4, 20'h03000, 1'b0);
    tick(100);
    ch_sgn = 1'b1;
    tick(30);
    check("t2_bus_idle", {31'd0, sram_bus_en}, 32'd0);
    win_next(8'd4, 20'h03000, 1'b0);
    tick(4);
    check("t2_nwr", wr_addr.size(), 4);
    chk_rec(0, 20'h03000, 31'd99, 1'b1);
    if (wr_cyc.size() == 4) check("t2_rec_span", wr_cyc[3] - wr_cyc[0], 9);
    check("t2_pulse", {16'd0, pulse_cnt}, 32'd1);
    check("t2_rec",   {16'd0, rec_cnt}, 32'd1);
    check("t2_clk",   clk_cnt, 32'd129);
    check("t2_ovf",   {31'd0, ovf}, 32'd0);

    // invalid channel 0: nothing recorded or counted
    clear_log();
    win_next(8'd0, 20'h02000, 1'b0);
    tick(10);
    ch_sgn = 1'b1;
    tick(20);
    win_next(8'd4, 20'h03000, 1'b0);
    tick(4);
    check("inv_nwr",   wr_addr.size(), 0);
    check("inv_pulse", {16'd0, pulse_cnt}, 32'd0);
    check("inv_clk",   clk_cnt, 32'd0);
    check("inv_ovf",   {31'd0, ovf}, 32'd0);

    // rise, fall 5 clk later, rise again while the buffer is full -> lost
    clear_log();
    win_next(8'd4, 20'h03000, 1'b0);
    tick(10);
    ch_sgn = 1'b1;
    tick(5);
    ch_sgn = 1'b0;
    tick(5);
    ch_sgn = 1'b1;
    tick(40);
    check("t3_ovf_set", {31'd0, ovf}, 32'd1);
    win_next(8'd4, 20'h03000, 1'b0);
    tick(4);
    check("t3_nwr",   wr_addr.size(), 8);
    chk_rec(0, 20'h03000, 31'd9, 1'b1);
    chk_rec(4, 20'h03004, 31'd14, 1'b0);
    check("t3_pulse", {16'd0, pulse_cnt}, 32'd2);
    check("t3_rec",   {16'd0, rec_cnt}, 32'd2);
    sample_en = 1'b0;
    tick(2);
    sample_en = 1'b1;
    tick(2);
    check("t3_ovf_clr", {31'd0, ovf}, 32'd0);

    // sync rises during byte2 of a record
    clear_log();
    win_next(8'd4, 20'h03000, 1'b0);
    tick(10);
    ch_sgn = 1'b1;
    tick(2);
    ch_sync = 1'b0;
    tick(7);
    sync_cnt  = 8'd5;
    addr_base = 20'h05000;
    ch_sync   = 1'b1;
    tick(4);
    check("t6_pulse_a", {16'd0, pulse_cnt}, 32'd1);
    check("t6_rec_a",   {16'd0, rec_cnt}, 32'd0);
    check("t6_clk_a",   clk_cnt, 32'd11);
    tick(16);
    ch_sgn = 1'b0;
    tick(30);
    win_next(8'd4, 20'h03000, 1'b0);
    tick(4);
    check("t6_nwr", wr_addr.size(), 8);
    chk_rec(0, 20'h03000, 31'd9, 1'b1);
    chk_rec(4, 20'h05004, 31'd19, 1'b0);
    check("t6_pulse_b", {16'd0, pulse_cnt}, 32'd0);
    check("t6_rec_b",   {16'd0, rec_cnt}, 32'd2);

    // asynchronous reset while the strobe is low
    tick(10);
    ch_sgn = 1'b1;
    for (int i = 0; i < 60 && sram_we_n; i++) @(negedge clk);
    check("t1_we_low_seen", {31'd0, sram_we_n}, 32'd0);
    mcu_n_rst = 1'b0;
    #1;
    check("t1_we_n",   {31'd0, sram_we_n}, 32'd1);
    check("t1_bus_en", {31'd0, sram_bus_en}, 32'd0);
    check("t1_addr",   {12'd0, sram_addr}, 32'd0);
    check("t1_data",   {24'd0, sram_data}, 32'd0);
    check("t1_rec",    {16'd0, rec_cnt}, 32'd0);
    check("t1_clk",    clk_cnt, 32'd0);
    tick(2);
    mcu_n_rst = 1'b1;
    tick(2);

    // channel 1, 4 KiB region: 1025 edges, 1024 fit
    clear_log();
    win_next(8'd1, 20'h00000, 1'b0);
    for (int i = 0; i < 1025; i++) begin
      tick(20);
      ch_sgn = ~ch_sgn;
    end
    tick(30);
    check("t4_nwr", wr_addr.size(), 4096);
    chk_rec(0, 20'h00000, 31'd19, 1'b1);
    if (wr_addr.size() >= 4096) begin
      check("t4_last_addr", {12'd0, wr_addr[4092]}, 32'h00FFC);
      check("t4_end_addr",  {12'd0, wr_addr[4095]}, 32'h00FFF);
    end
    check("t4_ovf", {31'd0, ovf}, 32'd1);
    sample_en = 1'b0;
    tick(2);
    sample_en = 1'b1;
    tick(2);

    // channel 10, 64 KiB region: all 1025 edges fit
    clear_log();
    win_next(8'd10, 20'h10000, 1'b0);
    tick(4);
    check("t4_rec",   {16'd0, rec_cnt}, 32'd1024);
    check("t4_pulse", {16'd0, pulse_cnt}, 32'd513);
    check("t5_ovf_clr", {31'd0, ovf}, 32'd0);
    for (int i = 0; i < 1025; i++) begin
      tick(20);
      ch_sgn = ~ch_sgn;
    end
    tick(30);
    check("t5_nwr", wr_addr.size(), 4100);
    if (wr_addr.size() >= 4100)
      check("t5_last_addr", {12'd0, wr_addr[4096]}, 32'h11000);
    check("t5_ovf", {31'd0, ovf}, 32'd0);
    win_next(8'd4, 20'h03000, 1'b0);
    tick(4);
    check("t5_rec",   {16'd0, rec_cnt}, 32'd1025);
    check("t5_pulse", {16'd0, pulse_cnt}, 32'd513);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
